// File: rtl/uart_io_pkg.sv
// Shared definitions for the CPU-side UART I/O controller:
// FSM state encoding, the reserved null byte and the default IN timeout.
package uart_io_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [7:0]  NULL_BYTE              = 8'h00;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/uart_io_timeout_cnt.sv
// IN-timeout counter: cleared while idle, counts WAIT cycles and flags the last
// allowed cycle. A LIMIT of 0 disables expiry, so an IN waits forever.
module uart_io_timeout_cnt #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit               ACTIVE = (LIMIT != 0);
    localparam logic [CNT_W-1:0] LAST   = ACTIVE ? CNT_W'(LIMIT - 1) : '0;

    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign expired = ACTIVE && (cnt_q == LAST);

    // Counting stops at LAST; the compare bounds it, so no wrap is possible.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && ACTIVE && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_io_controller.sv
// Sequences CPU IN/OUT instructions onto the request/response byte link: one-entry
// receive buffer, stalling IN with timeout, and a one-byte OUT holding register.
module uart_io_controller
    import uart_io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cpu_rd_req,
    input  logic       cpu_wr_req,
    input  logic [7:0] cpu_wr_data,
    output logic       cpu_stall,
    output logic       cpu_rd_valid,
    output logic [7:0] cpu_rd_data,
    output logic       cpu_timeout,
    output logic       tx_pending,
    output logic       err_overrun,
    output logic       ser_receive_flag,
    output logic       ser_send_flag,
    output logic [7:0] ser_in,
    input  logic [7:0] ser_out
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e     state_d, state_q;
    logic [7:0] rx_hold_d, rx_hold_q;
    logic       rx_full_d, rx_full_q;
    logic [7:0] tx_hold_d, tx_hold_q;
    logic       tx_pending_d, tx_pending_q;
    logic       err_d, err_q;
    logic       rd_valid_d, rd_valid_q;
    logic       timeout_d, timeout_q;
    logic [7:0] rd_data_d, rd_data_q;
    logic       stall_q;
    logic       rx_flag_q;
    logic       byte_ev, rx_take;
    logic       cnt_clear, cnt_en, cnt_expired;

    uart_io_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk     (CLOCK_50),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    assign byte_ev = (ser_out != NULL_BYTE);

    always_comb begin
        state_d      = state_q;
        rx_hold_d    = rx_hold_q;
        rx_full_d    = rx_full_q;
        tx_hold_d    = tx_hold_q;
        tx_pending_d = tx_pending_q;
        err_d        = err_q;
        rd_valid_d   = 1'b0;
        timeout_d    = 1'b0;
        rd_data_d    = rd_data_q;
        rx_take      = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (cpu_rd_req && rx_full_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rx_hold_q;
                    rx_full_d  = 1'b0;
                    rx_take    = byte_ev;
                end else if (cpu_rd_req && byte_ev) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ser_out;
                end else if (cpu_rd_req) begin
                    state_d = WAIT;
                end else begin
                    rx_take = byte_ev;
                end
            end
            WAIT: begin
                if (byte_ev) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = ser_out;
                end else if (cnt_expired) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    rd_data_d  = NULL_BYTE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte arriving while the buffer is still full is lost, even if the
        // buffered byte is being read out in the same cycle.
        if (rx_take) begin
            if (rx_full_q) begin
                err_d = 1'b1;
            end else begin
                rx_hold_d = ser_out;
                rx_full_d = 1'b1;
            end
        end

        if (byte_ev && tx_pending_q) begin
            tx_pending_d = 1'b0;
            if (cpu_wr_req) begin
                err_d = 1'b1;
            end
        end else if (cpu_wr_req) begin
            if (tx_pending_q) begin
                err_d = 1'b1;
            end else begin
                tx_hold_d    = cpu_wr_data;
                tx_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_hold_q    <= '0;
            rx_full_q    <= 1'b0;
            tx_hold_q    <= '0;
            tx_pending_q <= 1'b0;
            err_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            timeout_q    <= 1'b0;
            rd_data_q    <= '0;
            stall_q      <= 1'b0;
            rx_flag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_hold_q    <= rx_hold_d;
            rx_full_q    <= rx_full_d;
            tx_hold_q    <= tx_hold_d;
            tx_pending_q <= tx_pending_d;
            err_q        <= err_d;
            rd_valid_q   <= rd_valid_d;
            timeout_q    <= timeout_d;
            rd_data_q    <= rd_data_d;
            stall_q      <= (state_d == WAIT);
            rx_flag_q    <= 1'b1;
        end
    end

    assign cpu_stall        = stall_q;
    assign cpu_rd_valid     = rd_valid_q;
    assign cpu_rd_data      = rd_data_q;
    assign cpu_timeout      = timeout_q;
    assign tx_pending       = tx_pending_q;
    assign err_overrun      = err_q;
    assign ser_receive_flag = rx_flag_q;
    assign ser_send_flag    = tx_pending_q;
    assign ser_in           = tx_hold_q;

endmodule

// File: tb/tb_uart_io_controller.sv
// Bench for uart_io_controller: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the IN/OUT link behaviour.
module tb_uart_io_controller;

    localparam int unsigned TMO = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       cpu_rd_req, cpu_wr_req;
    logic [7:0] cpu_wr_data;
    logic       cpu_stall, cpu_rd_valid, cpu_timeout, tx_pending, err_overrun;
    logic [7:0] cpu_rd_data;
    logic       ser_receive_flag, ser_send_flag;
    logic [7:0] ser_in, ser_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] rxq[$];
    bit         m_waiting;
    int         m_waited;
    bit         m_txp, m_ovr, m_valid, m_to, m_rf;
    logic [7:0] m_txb, m_rdd;

    uart_io_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .cpu_rd_req       (cpu_rd_req),
        .cpu_wr_req       (cpu_wr_req),
        .cpu_wr_data      (cpu_wr_data),
        .cpu_stall        (cpu_stall),
        .cpu_rd_valid     (cpu_rd_valid),
        .cpu_rd_data      (cpu_rd_data),
        .cpu_timeout      (cpu_timeout),
        .tx_pending       (tx_pending),
        .err_overrun      (err_overrun),
        .ser_receive_flag (ser_receive_flag),
        .ser_send_flag    (ser_send_flag),
        .ser_in           (ser_in),
        .ser_out          (ser_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        m_waiting = 0; m_waited = 0;
        m_txp = 0; m_ovr = 0; m_valid = 0; m_to = 0; m_rf = 0;
        m_txb = 8'h00; m_rdd = 8'h00;
    endtask

    task automatic model_step(input bit rd, input bit wr, input logic [7:0] wd,
                              input logic [7:0] so);
        bit ev;
        ev = (so != 8'h00);
        m_valid = 0; m_to = 0; m_rf = 1;
        if (!m_waiting) begin
            if (rd && rxq.size() > 0) begin
                m_valid = 1;
                m_rdd = rxq.pop_front();
                if (ev) m_ovr = 1;
            end else if (rd && ev) begin
                m_valid = 1;
                m_rdd = so;
            end else if (rd) begin
                m_waiting = 1;
                m_waited = 0;
            end else if (ev) begin
                if (rxq.size() == 0) rxq.push_back(so);
                else m_ovr = 1;
            end
        end else begin
            m_waited++;
            if (ev) begin
                m_waiting = 0; m_valid = 1; m_rdd = so;
            end else if (m_waited == TMO) begin
                m_waiting = 0; m_valid = 1; m_to = 1; m_rdd = 8'h00;
            end
        end
        if (ev && m_txp) begin
            m_txp = 0;
            if (wr) m_ovr = 1;
        end else if (wr) begin
            if (m_txp) m_ovr = 1;
            else begin
                m_txp = 1;
                m_txb = wd;
            end
        end
    endtask

    task automatic compare_all();
        chk("rd_valid", {7'd0, cpu_rd_valid}, {7'd0, m_valid});
        chk("rd_data", cpu_rd_data, m_rdd);
        chk("timeout", {7'd0, cpu_timeout}, {7'd0, m_to});
        chk("stall", {7'd0, cpu_stall}, {7'd0, m_waiting});
        chk("tx_pending", {7'd0, tx_pending}, {7'd0, m_txp});
        chk("send_flag", {7'd0, ser_send_flag}, {7'd0, m_txp});
        chk("ser_in", ser_in, m_txb);
        chk("err_overrun", {7'd0, err_overrun}, {7'd0, m_ovr});
        chk("recv_flag", {7'd0, ser_receive_flag}, {7'd0, m_rf});
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [7:0] wd, input logic [7:0] so);
        cpu_rd_req = rd; cpu_wr_req = wr; cpu_wr_data = wd; ser_out = so;
        @(posedge CLOCK_50); #1;
        model_step(rd, wr, wd, so);
        cpu_rd_req = 0; cpu_wr_req = 0; cpu_wr_data = 8'h00; ser_out = 8'h00;
        compare_all();
    endtask

    task automatic rst_cyc();
        reset = 1;
        @(posedge CLOCK_50); #1;
        reset = 0;
        model_reset();
        compare_all();
    endtask

    initial begin
        reset = 1; cpu_rd_req = 0; cpu_wr_req = 0; cpu_wr_data = 8'h00; ser_out = 8'h00;
        model_reset();
        rst_cyc();
        chk("reset_stall", {7'd0, cpu_stall}, 8'd0);
        cyc(0, 0, 8'h00, 8'h00);
        chk("recv_flag_up", {7'd0, ser_receive_flag}, 8'd1);

        // Buffered byte read out
        cyc(0, 0, 8'h00, 8'h41);
        cyc(1, 0, 8'h00, 8'h00);
        chk("t1_valid", {7'd0, cpu_rd_valid}, 8'd1);
        chk("t1_data", cpu_rd_data, 8'h41);
        cyc(0, 0, 8'h00, 8'h00);
        chk("t1_pulse", {7'd0, cpu_rd_valid}, 8'd0);

        // Stalled IN satisfied after 10 cycles
        cyc(1, 0, 8'h00, 8'h00);
        chk("t2_stall", {7'd0, cpu_stall}, 8'd1);
        repeat (9) cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h5A);
        chk("t2_data", cpu_rd_data, 8'h5A);
        chk("t2_valid", {7'd0, cpu_rd_valid}, 8'd1);
        chk("t2_no_timeout", {7'd0, cpu_timeout}, 8'd0);
        chk("t2_unstall", {7'd0, cpu_stall}, 8'd0);

        // Timeout after TMO stalled cycles
        cyc(1, 0, 8'h00, 8'h00);
        repeat (TMO - 1) cyc(0, 0, 8'h00, 8'h00);
        chk("t3_still_stall", {7'd0, cpu_stall}, 8'd1);
        cyc(0, 0, 8'h00, 8'h00);
        chk("t3_timeout", {7'd0, cpu_timeout}, 8'd1);
        chk("t3_valid", {7'd0, cpu_rd_valid}, 8'd1);
        chk("t3_data", cpu_rd_data, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("t3_pulse", {7'd0, cpu_timeout}, 8'd0);
        // Byte on the last allowed cycle wins
        cyc(1, 0, 8'h00, 8'h00);
        repeat (TMO - 1) cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h77);
        chk("t3b_data", cpu_rd_data, 8'h77);
        chk("t3b_no_timeout", {7'd0, cpu_timeout}, 8'd0);

        // Receive overrun keeps the first byte
        cyc(0, 0, 8'h00, 8'h31);
        cyc(0, 0, 8'h00, 8'h32);
        chk("t4_overrun", {7'd0, err_overrun}, 8'd1);
        cyc(1, 0, 8'h00, 8'h00);
        chk("t4_data", cpu_rd_data, 8'h31);
        rst_cyc();

        // OUT holding register
        cyc(0, 1, 8'hC3, 8'h00);
        chk("t5_send", {7'd0, ser_send_flag}, 8'd1);
        chk("t5_ser_in", ser_in, 8'hC3);
        cyc(0, 0, 8'h00, 8'h10);
        chk("t5_cleared", {7'd0, tx_pending}, 8'd0);
        cyc(0, 1, 8'hC3, 8'h00);
        cyc(0, 1, 8'h99, 8'h00);
        chk("t5_overrun", {7'd0, err_overrun}, 8'd1);
        chk("t5_hold", ser_in, 8'hC3);
        cyc(1, 0, 8'h00, 8'h00);
        chk("t5_rx", cpu_rd_data, 8'h10);

        // Reset in the middle of a stalled IN
        cyc(1, 0, 8'h00, 8'h00);
        repeat (3) cyc(0, 0, 8'h00, 8'h00);
        rst_cyc();
        chk("t6_stall", {7'd0, cpu_stall}, 8'd0);
        chk("t6_valid", {7'd0, cpu_rd_valid}, 8'd0);
        chk("t6_timeout", {7'd0, cpu_timeout}, 8'd0);
        chk("t6_txp", {7'd0, tx_pending}, 8'd0);
        chk("t6_err", {7'd0, err_overrun}, 8'd0);
        repeat (TMO + 2) cyc(0, 0, 8'h00, 8'h00);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit         rd, wr;
            logic [7:0] wd, so;
            if ($urandom_range(0, 299) == 0) begin
                rst_cyc();
            end else begin
                rd = ($urandom_range(0, 7) == 0);
                wr = ($urandom_range(0, 9) == 0);
                wd = 8'($urandom);
                so = ($urandom_range(0, 21) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                cyc(rd, wr, wd, so);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
